// File: rtl/axis_upsz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsz_pkg
//  Purpose  : Shared widths, helpers and types for the AXI4-Stream upsizer.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_upsz_pkg;

    // Default build configuration; the upsizer parameters default to these.
    localparam int c_S_DATA_W = 64;
    localparam int c_RATIO    = 8;
    localparam int c_M_DATA_W = c_S_DATA_W * c_RATIO;
    localparam int c_S_KEEP_W = c_S_DATA_W / 8;
    localparam int c_M_KEEP_W = c_M_DATA_W / 8;

    typedef enum logic [0:0] {
        LANE_FILL = 1'b0,
        LANE_LAST = 1'b1
    } lane_phase_t;

    typedef struct packed {
        logic [c_M_DATA_W-1:0] data;
        logic [c_M_KEEP_W-1:0] keep;
        logic                  last;
    } upsz_beat_t;

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lane_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_upsizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsizer_if
//  Purpose  : AXI4-Stream bundle (data, keep, valid, last, ready) with modports.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_upsizer_if #(
    parameter int DATA_W = 64
);
    import axis_upsz_pkg::*;

    localparam int c_KEEP_W = keep_w(DATA_W);

    logic [DATA_W-1:0]   tdata;
    logic [c_KEEP_W-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_upsz_accum.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsz_accum
//  Purpose  : Lane counter and per-lane accumulator; merges the completing
//             beat with stored lanes into one wide word.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_upsz_accum
    import axis_upsz_pkg::*;
#(
    parameter int S_DATA_W = c_S_DATA_W,
    parameter int RATIO    = c_RATIO
) (
    input  wire logic                                aclk,
    input  wire logic                                aresetn,
    input  wire logic                                i_accept,
    input  wire logic [S_DATA_W-1:0]                 i_data,
    input  wire logic [keep_w(S_DATA_W)-1:0]         i_keep,
    input  wire logic                                i_last,
    output      logic                                o_complete,
    output      logic [S_DATA_W*RATIO-1:0]           o_word,
    output      logic [keep_w(S_DATA_W)*RATIO-1:0]   o_keep
);

    localparam int                 c_KEEP_W    = keep_w(S_DATA_W);
    localparam int                 c_CNT_W     = lane_cnt_w(RATIO);
    localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(RATIO - 1);

    logic [c_CNT_W-1:0]                r_lane;
    logic [RATIO-2:0][S_DATA_W-1:0]    r_acc_data;
    logic [RATIO-2:0][c_KEEP_W-1:0]    r_acc_keep;
    logic [RATIO-2:0]                  w_lane_we;
    lane_phase_t                       w_phase;

    assign w_phase    = (r_lane == c_LAST_LANE) ? LANE_LAST : LANE_FILL;
    assign o_complete = i_accept && (i_last || (w_phase == LANE_LAST));

    // The last lane is never stored: it always bypasses straight into the output word.
    for (genvar j = 0; j < RATIO - 1; j++) begin : g_we
        assign w_lane_we[j] = i_accept && !o_complete && (r_lane == c_CNT_W'(j));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lane     <= '0;
            r_acc_data <= '0;
            r_acc_keep <= '0;
        end else begin
            if (o_complete) begin
                r_lane <= '0;
            end else if (i_accept) begin
                r_lane <= r_lane + c_CNT_W'(1);
            end
            for (int j = 0; j < RATIO - 1; j++) begin
                if (w_lane_we[j]) begin
                    r_acc_data[j] <= i_data;
                    r_acc_keep[j] <= i_keep;
                end
            end
        end
    end

    // Lanes above the current one read as zero so an early flush carries no stale data.
    for (genvar j = 0; j < RATIO; j++) begin : g_lane
        if (j < RATIO - 1) begin : g_fill
            assign o_word[lane_lsb(j, S_DATA_W) +: S_DATA_W] =
                (r_lane >  c_CNT_W'(j)) ? r_acc_data[j] :
                (r_lane == c_CNT_W'(j)) ? i_data : '0;
            assign o_keep[lane_lsb(j, c_KEEP_W) +: c_KEEP_W] =
                (r_lane >  c_CNT_W'(j)) ? r_acc_keep[j] :
                (r_lane == c_CNT_W'(j)) ? i_keep : '0;
        end else begin : g_last
            assign o_word[lane_lsb(j, S_DATA_W) +: S_DATA_W] =
                (w_phase == LANE_LAST) ? i_data : '0;
            assign o_keep[lane_lsb(j, c_KEEP_W) +: c_KEEP_W] =
                (w_phase == LANE_LAST) ? i_keep : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_upsizer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsizer
//  Purpose  : AXI4-Stream width upsizer, RATIO narrow beats per registered
//             wide beat. Define AXIS_UPSZ_TKEEP_EN to honour slave TKEEP.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_upsizer
    import axis_upsz_pkg::*;
#(
    parameter int S_DATA_W = c_S_DATA_W,
    parameter int RATIO    = c_RATIO
) (
    input  wire logic        aclk,
    input  wire logic        aresetn,
    axis_upsizer_if.slave    s_axis,
    axis_upsizer_if.master   m_axis
);

    localparam int c_M_DATA_W = S_DATA_W * RATIO;
    localparam int c_S_KEEP_W = keep_w(S_DATA_W);
    localparam int c_M_KEEP_W = keep_w(c_M_DATA_W);

    typedef struct packed {
        logic [c_M_DATA_W-1:0] data;
        logic [c_M_KEEP_W-1:0] keep;
        logic                  last;
    } out_beat_t;

    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic [c_S_KEEP_W-1:0] w_s_keep;
    logic [c_M_DATA_W-1:0] w_word;
    logic [c_M_KEEP_W-1:0] w_keep;
    out_beat_t             r_out;
    logic                  r_valid;

    // Ready looks only at the output stage, so a completing beat always has room.
    assign w_s_ready     = aresetn && (!r_valid || m_axis.tready);
    assign w_accept      = s_axis.tvalid && w_s_ready;
    assign s_axis.tready = w_s_ready;

`ifdef AXIS_UPSZ_TKEEP_EN
    assign w_s_keep = s_axis.tkeep;
`else
    assign w_s_keep = '1;
`endif

    axis_upsz_accum #(
        .S_DATA_W (S_DATA_W),
        .RATIO    (RATIO)
    ) u_accum (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_accept   (w_accept),
        .i_data     (s_axis.tdata),
        .i_keep     (w_s_keep),
        .i_last     (s_axis.tlast),
        .o_complete (w_complete),
        .o_word     (w_word),
        .o_keep     (w_keep)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_complete) begin
            r_out   <= '{data: w_word, keep: w_keep, last: s_axis.tlast};
            r_valid <= 1'b1;
        end else if (m_axis.tready) begin
            r_valid    <= 1'b0;
            r_out.last <= 1'b0;
        end
    end

    assign m_axis.tdata  = r_out.data;
    assign m_axis.tkeep  = r_out.keep;
    assign m_axis.tlast  = r_out.last;
    assign m_axis.tvalid = r_valid;

endmodule
`default_nettype wire

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Parametrised AXI4-Stream width upsizer. Packs RATIO narrow beats (S_DATA_W) into one wide beat (S_DATA_W*RATIO).
- Sits between the DMA (narrow) side and wide datapath consumers such as the LDPC core.
- Generalises the fixed 64-to-512 collector:
  - Any ratio is supported.
  - Packets that end on a partial word are flushed early, with M_AXIS_TKEEP marking the valid bytes.
  - The output is registered, with backpressure handling at full throughput.

Parameters:
S_DATA_W, 64, slave data width in bits; multiple of 8, at least 8
RATIO, 8, narrow beats per wide beat; at least 2
M_DATA_W, S_DATA_W*RATIO, derived, not overridable
CNT_W, $clog2(RATIO), derived lane-counter width

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  reset, asynchronous assert, active-low; release is synchronous to aclk (released by an upstream synchroniser)
S_AXIS_TDATA  in  S_DATA_W  narrow data
S_AXIS_TVALID  in  1  narrow valid
S_AXIS_TLAST  in  1  end of packet
S_AXIS_TKEEP  in  S_DATA_W/8  byte qualifiers; present only with AXIS_UPSZ_TKEEP_EN
S_AXIS_TREADY  out  1  narrow ready
M_AXIS_TDATA  out  M_DATA_W  wide data
M_AXIS_TKEEP  out  M_DATA_W/8  wide byte qualifiers
M_AXIS_TVALID  out  1  wide valid
M_AXIS_TLAST  out  1  end of packet
M_AXIS_TREADY  in  1  wide ready

Behaviour:
- Reset values (aresetn low): M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TKEEP=0, M_AXIS_TDATA=0, lane counter=0, accumulator=0.
  - Asserting reset mid-packet discards any partial word and any pending output beat.
- Handshakes:
  - A narrow beat is accepted when S_AXIS_TVALID && S_AXIS_TREADY.
  - A wide beat is accepted when M_AXIS_TVALID && M_AXIS_TREADY.
  - S_AXIS_TREADY = aresetn && (!M_AXIS_TVALID || M_AXIS_TREADY). It is combinational from M_AXIS_TREADY and never depends on S_AXIS_TVALID.
- Packing order is little-endian by lane:
  - The beat accepted at lane counter k goes to bits [k*S_DATA_W +: S_DATA_W].
  - Lane 0 is the first beat of each wide word.
- Lane counter states: FILL(0..RATIO-2) and the last lane (RATIO-1).
  - An accepted beat with lane<RATIO-1 and TLAST=0 is written into the accumulator and the counter increments.
  - An accepted beat with lane==RATIO-1, or with TLAST=1 at any lane, is a completing beat:
    - The accumulator plus the current beat load the output register in the same edge.
    - M_AXIS_TVALID goes to 1 and the counter returns to 0.
    - M_AXIS_TLAST takes the beat's TLAST.
- Latency: a completing beat is visible on M_AXIS_* the cycle after acceptance.
- Throughput: with M_AXIS_TREADY held high, one narrow beat is accepted every cycle, with no bubbles at word boundaries.
- Early flush (TLAST on lane k<RATIO-1):
  - Lanes above k are driven to zero in TDATA.
  - M_AXIS_TKEEP has the bits for lanes 0..k set and all others cleared.
- TKEEP for a full word is all ones (without the macro).
- Output register holds stable (data, keep, last) while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
  - Non-completing beats are still stalled, because S_AXIS_TREADY is low in this condition.
- Simultaneous output drain and completing input in the same cycle: the output register reloads with the new word and M_AXIS_TVALID stays 1.
- Output drained with no new completing beat: M_AXIS_TVALID goes to 0 and M_AXIS_TLAST goes to 0.
- TLAST on a beat at lane RATIO-1 produces a full word with TLAST=1 and all-ones keep.
- Single-beat packet (TLAST on lane 0) produces one wide beat with keep = lane-0 bytes only.

Optional Feature:
- Macro AXIS_UPSZ_TKEEP_EN.
- Defined:
  - The S_AXIS_TKEEP port exists.
  - Each lane's keep bits in M_AXIS_TKEEP are the captured S_AXIS_TKEEP of that beat.
  - Masked bytes are passed through unmodified in TDATA, not zeroed.
  - Unfilled lanes after an early flush still have keep 0 and data 0.
- Undefined: the port is absent and every accepted beat is treated as all-bytes-valid.

Decomposition:
- Package axis_upsz_pkg holds:
  - the lane-index and keep-width helper functions;
  - the localparam computing M_DATA_W and keep widths;
  - a packed struct for the output beat {data, keep, last}.
- One sub-module, axis_upsz_accum: the accumulator RAM-less register array with lane counter and lane write enables.
  - The top level holds the output register and handshake logic.

Test Plan:
- Reset, then M_AXIS_TREADY=1; send 8 beats 64'h0706050403020100 .. 64'h3F3E3D3C3B3A3938 with TLAST on the 8th.
  - Expect exactly one wide beat with TDATA bytes 0x00..0x3F ascending from bit 0, TKEEP=all ones, TLAST=1, one cycle after the 8th accept.
- Send 12 beats 0x00..0x5F, TLAST on the 12th.
  - Expect beat 1 full with TLAST=0.
  - Expect beat 2 with bytes 0x40..0x5F in bits [255:0], bits [511:256]=0, TKEEP=64'h0000_0000_FFFF_FFFF, TLAST=1.
- Backpressure: hold M_AXIS_TREADY=0 after the first wide word completes.
  - S_AXIS_TREADY must drop the next cycle; TDATA/TKEEP/TLAST must stay stable for 10 cycles.
  - Release TREADY: no beat is lost or duplicated (scoreboard check over 64 random beats with random TREADY).
- Continuous 32-beat stream with TVALID and M_AXIS_TREADY always 1.
  - S_AXIS_TREADY stays high every cycle; 4 wide beats appear on consecutive 8-cycle boundaries.
- Assert aresetn low after 3 beats of a packet.
  - M_AXIS_TVALID=0 immediately; the next 8-beat packet emerges clean, with no residue from the first 3 beats.
- With AXIS_UPSZ_TKEEP_EN: send a single beat with TKEEP=8'h0F and TLAST=1.
  - Expect M_AXIS_TKEEP=64'h0000_0000_0000_000F and TLAST=1.
